truth_table_sequencer: RTL and testbench

Sequential stimulus/response stage that drives every input combination of a small combinational gate block, such as the 3-input gate modules in this exercise set. It holds each combination for a programmable settle time and samples the gate's 1-bit output. It assembles the samples into a truth-table word and compares it against an expected word. It sits directly upstream of the gate under test, replacing hand-written delay-stepped stimulus, and consumes the gate's output.

---
 rtl/truth_table_sequencer_pkg.sv | 20 ++
 rtl/truth_table_sequencer_settle_timer.sv | 37 +++
 rtl/truth_table_sequencer.sv | 118 +++++++++++
 tb/tb_truth_table_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding,
// settle counter width and the truth-table width helper.
package truth_table_sequencer_pkg;

   // Width of the settle counter; SETTLE values 0..15 fit.
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_e;

   // Number of rows in the truth table of an n-input gate.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that times the hold window of each input vector.
// expire_o is high while the count is 1, i.e. in the last hold cycle.
module settle_timer
   import truth_table_sequencer_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [SETTLE_W-1:0] load_val_i,
   output logic                expire_o
);

   logic [SETTLE_W-1:0] cnt_q;
   logic [SETTLE_W-1:0] cnt_d;

   // Load has priority; otherwise count down and rest at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks every input vector of a small combinational
// gate, holds each for SETTLE+1 cycles, samples the gate output into a
// truth-table word and compares it with the expected word latched at start.
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [tt_width(N_IN)-1:0]   expected,
   output logic [N_IN-1:0]             vec,
   input  logic                        resp,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [tt_width(N_IN)-1:0]   truth_table
);

   localparam int TW = tt_width(N_IN);
   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
   // With no settle time the FSM skips HOLD and samples every cycle.
   localparam state_e AFTER_LOAD = (SETTLE == 0) ? SAMPLE : HOLD;

   state_e          state_q, state_d;
   logic [N_IN-1:0] vec_q,   vec_d;
   logic [TW-1:0]   table_q, table_d;
   logic [TW-1:0]   exp_q,   exp_d;
   logic            pass_q,  pass_d;
   logic            done_q,  done_d;
   logic            tmr_load;
   logic            tmr_expire;

   settle_timer u_settle_timer (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LD),
      .expire_o   (tmr_expire)
   );

   // Next-state logic for the FSM, vector counter, capture and compare.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      table_d  = table_q;
      exp_d    = exp_q;
      pass_d   = pass_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      case (state_q)
         IDLE: begin
            vec_d = '0;
            if (start) begin
               exp_d    = expected;
               table_d  = '0;
               pass_d   = 1'b0;
               tmr_load = 1'b1;
               state_d  = AFTER_LOAD;
            end
         end
         HOLD: begin
            if (tmr_expire) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            table_d[vec_q] = resp;
            if (&vec_q) begin
               // Compare uses table_d so the final sample is included.
               pass_d  = (table_d == exp_q);
               done_d  = 1'b1;
               vec_d   = '0;
               state_d = FINISH;
            end else begin
               vec_d    = vec_q + 1'b1;
               tmr_load = 1'b1;
               state_d  = AFTER_LOAD;
            end
         end
         FINISH: begin
            vec_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         table_q <= '0;
         exp_q   <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         table_q <= table_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign vec         = vec_q;
   assign truth_table = table_q;
   assign pass        = pass_q;
   assign done        = done_q;
   assign busy        = (state_q == HOLD) || (state_q == SAMPLE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=0)
// each driving a gate modelled as a lookup table indexed by vec.
module tb_truth_table_sequencer;

   localparam int TW  = 8;
   localparam int S_A = 1;
   localparam int S_B = 0;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [7:0] exp_a, exp_b;
   logic [7:0] gate_a, gate_b;
   logic [2:0] vec_a, vec_b;
   logic       resp_a, resp_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [7:0] tt_a, tt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign resp_a = gate_a[vec_a];
   assign resp_b = gate_b[vec_b];

   truth_table_sequencer #(.N_IN(3), .SETTLE(S_A)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .expected(exp_a),
      .vec(vec_a), .resp(resp_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .truth_table(tt_a));

   truth_table_sequencer #(.N_IN(3), .SETTLE(S_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .expected(exp_b),
      .vec(vec_b), .resp(resp_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .truth_table(tt_b));

   // Truth table of an arbitrary 3-input function, built row by row.
   function automatic logic [7:0] gate_ab_or_ac();
      logic [7:0] t;
      for (int i = 0; i < 8; i++) begin
         logic a, b, c;
         a = i[2]; b = i[1]; c = i[0];
         t[i] = (a & b) | (a & c);
      end
      return t;
   endfunction

   // One full sweep on instance which (0 = A, 1 = B), checked cycle by cycle.
   // poke_k >= 0 pulses start with expected = 0 at that cycle of the sweep.
   task automatic run_sweep(input bit which, input logic [7:0] gate,
                            input logic [7:0] exp, input int poke_k,
                            input string nm);
      int s, total;
      logic [2:0] v;
      logic b, d, p;
      logic [7:0] t;
      s     = which ? S_B : S_A;
      total = TW * (s + 1);
      @(negedge clk);
      if (which) begin gate_b = gate; exp_b = exp; start_b = 1'b1; end
      else       begin gate_a = gate; exp_a = exp; start_a = 1'b1; end
      @(negedge clk);
      if (which) start_b = 1'b0; else start_a = 1'b0;
      for (int k = 0; k <= total + 1; k++) begin
         if (k > 0) @(negedge clk);
         if (k == poke_k) begin
            if (which) begin start_b = 1'b1; exp_b = 8'h00; end
            else       begin start_a = 1'b1; exp_a = 8'h00; end
         end else if (k == poke_k + 1) begin
            if (which) start_b = 1'b0; else start_a = 1'b0;
         end
         v = which ? vec_b  : vec_a;
         b = which ? busy_b : busy_a;
         d = which ? done_b : done_a;
         p = which ? pass_b : pass_a;
         t = which ? tt_b   : tt_a;
         if (k < total) begin
            checks += 3;
            if (int'(v) !== k / (s + 1)) begin
               errors++;
               $display("FAIL %s vec k=%0d got %0d want %0d", nm, k, v, k / (s + 1));
            end
            if (b !== 1'b1) begin
               errors++;
               $display("FAIL %s busy k=%0d got %b want 1", nm, k, b);
            end
            if (d !== 1'b0) begin
               errors++;
               $display("FAIL %s done k=%0d got %b want 0", nm, k, d);
            end
         end else begin
            checks += 4;
            if (d !== (k == total)) begin
               errors++;
               $display("FAIL %s done k=%0d got %b want %b", nm, k, d, k == total);
            end
            if (b !== 1'b0) begin
               errors++;
               $display("FAIL %s busy k=%0d got %b want 0", nm, k, b);
            end
            if (t !== gate) begin
               errors++;
               $display("FAIL %s table k=%0d got %h want %h", nm, k, t, gate);
            end
            if (p !== (gate == exp)) begin
               errors++;
               $display("FAIL %s pass k=%0d got %b want %b", nm, k, p, gate == exp);
            end
            if (k == total + 1) begin
               checks++;
               if (v !== 3'd0) begin
                  errors++;
                  $display("FAIL %s vec_idle got %0d want 0", nm, v);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      exp_a = 8'h00; exp_b = 8'h00; gate_a = 8'h00; gate_b = 8'h00;
      repeat (3) @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         checks += 2;
         if ({vec_a, busy_a, done_a, pass_a, tt_a} !== 14'd0) begin
            errors++;
            $display("FAIL reset_a phase=%0d got %h want 0", r, {vec_a, busy_a, done_a, pass_a, tt_a});
         end
         if ({vec_b, busy_b, done_b, pass_b, tt_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_b phase=%0d got %h want 0", r, {vec_b, busy_b, done_b, pass_b, tt_b});
         end
         reset = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_gate_match();
      run_sweep(1'b0, gate_ab_or_ac(), 8'hE0, -1, "gate_match");
   endtask

   task automatic test_gate_mismatch();
      run_sweep(1'b0, gate_ab_or_ac(), 8'hE1, -1, "gate_mismatch");
   endtask

   task automatic test_settle0();
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = (i % 2 == 1);
      run_sweep(1'b1, t, 8'hAA, -1, "settle0");
   endtask

   task automatic test_start_ignored();
      run_sweep(1'b0, gate_ab_or_ac(), 8'hE0, 5, "start_ignored_a");
      run_sweep(1'b1, 8'h5C, 8'h5C, 3, "start_ignored_b");
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         logic [7:0] g, e;
         g = 8'($urandom);
         e = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
         run_sweep(1'(n % 2), g, e, -1, "random");
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      @(negedge clk);
      gate_a = 8'hFF; exp_a = 8'hFF; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      waited = 0;
      while (vec_a !== 3'd5 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (vec_a !== 3'd5) begin
         errors++;
         $display("FAIL reset_mid wait_vec5 got %0d want 5", vec_a);
      end
      #2 reset = 1'b1;
      #1;
      checks += 5;
      if (vec_a !== 3'd0) begin errors++; $display("FAIL reset_mid vec got %0d want 0", vec_a); end
      if (tt_a !== 8'h00) begin errors++; $display("FAIL reset_mid table got %h want 00", tt_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy_a); end
      if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_mid pass got %b want 0", pass_a); end
      if (done_a !== 1'b0) begin errors++; $display("FAIL reset_mid done got %b want 0", done_a); end
      @(negedge clk);
      reset = 1'b0;
      run_sweep(1'b0, gate_ab_or_ac(), 8'hE0, -1, "post_reset");
   endtask

   task automatic test_back_to_back();
      int times[$];
      int cyc;
      @(negedge clk);
      gate_a = gate_ab_or_ac(); exp_a = 8'hE0; start_a = 1'b1;
      cyc = 0;
      while (times.size() < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done_a === 1'b1) begin
            times.push_back(cyc);
            checks += 2;
            if (tt_a !== 8'hE0) begin errors++; $display("FAIL b2b table got %h want e0", tt_a); end
            if (pass_a !== 1'b1) begin errors++; $display("FAIL b2b pass got %b want 1", pass_a); end
         end
      end
      start_a = 1'b0;
      checks++;
      if (times.size() != 3) begin
         errors++;
         $display("FAIL b2b done_count got %0d want 3", times.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (times[i] - times[i-1] != TW * (S_A + 1) + 2) begin
               errors++;
               $display("FAIL b2b spacing got %0d want %0d", times[i] - times[i-1], TW * (S_A + 1) + 2);
            end
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL b2b stop got busy=%b done=%b want 0 0", busy_a, done_a);
      end
   endtask

   initial begin
      test_reset();
      test_gate_match();
      test_gate_mismatch();
      test_settle0();
      test_start_ignored();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
